bip_control_unit: RTL

- Instruction sequencer for the accumulator CPU.
- Drives the program-memory address, consumes the 16-bit instruction (5-bit opcode, 11-bit operand) one cycle later, and sequences accumulator, ALU and data-memory control.
- Sits between programMemory and the datapath (accumulator, ALU, data RAM).
- Stops permanently on HALT until reset.

---
 rtl/bip_pkg.sv | 16 +
 rtl/bip_decoder.sv | 21 ++
 rtl/bip_control_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/bip_pkg.sv
// bip_pkg: shared opcodes, FSM states and accumulator source codes for the BIP control unit
package bip_pkg;
    localparam int OP_W = 5;
    localparam logic [OP_W-1:0] OP_HALT  = 5'd0;
    localparam logic [OP_W-1:0] OP_STORE = 5'd1;
    localparam logic [OP_W-1:0] OP_LD    = 5'd2;
    localparam logic [OP_W-1:0] OP_LDI   = 5'd3;
    localparam logic [OP_W-1:0] OP_ADD   = 5'd4;
    localparam logic [OP_W-1:0] OP_ADDI  = 5'd5;
    localparam logic [OP_W-1:0] OP_SUB   = 5'd6;
    localparam logic [OP_W-1:0] OP_SUBI  = 5'd7;
    localparam logic [1:0] SEL_RAM = 2'd0;
    localparam logic [1:0] SEL_IMM = 2'd1;
    localparam logic [1:0] SEL_ALU = 2'd2;
    typedef enum logic [1:0] {FETCH, DECODE, MEMWB, HALT} state_t;
endpackage

// File: rtl/bip_decoder.sv
// bip_decoder: combinational opcode decode; opcode in, {is_mem, is_store, is_halt, is_imm, sel_a, sel_b, op} out
module bip_decoder
    import bip_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output logic            is_mem,
    output logic            is_store,
    output logic            is_halt,
    output logic            is_imm,
    output logic [1:0]      sel_a,
    output logic            sel_b,
    output logic            op
);
    assign is_mem   = opcode == OP_LD || opcode == OP_ADD || opcode == OP_SUB;
    assign is_store = opcode == OP_STORE;
    assign is_halt  = opcode == OP_HALT;
    assign is_imm   = opcode == OP_LDI || opcode == OP_ADDI || opcode == OP_SUBI;
    assign sel_a    = opcode == OP_LDI ? SEL_IMM : (opcode == OP_LD ? SEL_RAM : ((is_mem || is_imm) ? SEL_ALU : SEL_RAM));
    assign sel_b    = opcode == OP_ADDI || opcode == OP_SUBI;
    assign op       = opcode == OP_SUB || opcode == OP_SUBI;
endmodule

// File: rtl/bip_control_unit.sv
// bip_control_unit: accumulator-CPU instruction sequencer (FETCH/DECODE/MEMWB/HALT)
// ports: i_clk, i_reset (async active-low), i_enable, o_PcAddr, i_Instr, o_Operand,
//        o_SelA, o_SelB, o_Op, o_WrAcc, o_RdRam, o_WrRam, o_Halt; o_CycleCount when CYCLE_COUNT_EN is defined
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int NBITS_O  = 11,
    parameter int NBITS_D  = 16,
    parameter int NBITS_OP = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    output logic [NBITS_O-1:0] o_PcAddr,
    input  logic [NBITS_D-1:0] i_Instr,
    output logic [NBITS_O-1:0] o_Operand,
    output logic [1:0]         o_SelA,
    output logic               o_SelB,
    output logic               o_Op,
    output logic               o_WrAcc,
    output logic               o_RdRam,
    output logic               o_WrRam,
`ifdef CYCLE_COUNT_EN
    output logic [31:0]        o_CycleCount,
`endif
    output logic               o_Halt
);
    state_t              state;
    logic [NBITS_O-1:0]  pc;
    logic [NBITS_O-1:0]  opnd_q;
    logic [NBITS_OP-1:0] op_q;
    logic [NBITS_OP-1:0] opcode;
    logic                dec, memwb, wr_acc;
    logic                d_mem, d_store, d_halt, d_imm, d_sel_b, d_op;
    logic [1:0]          d_sel_a;
    assign dec    = state == DECODE;
    assign memwb  = state == MEMWB;
    // MEMWB decodes the captured opcode since the memory output is no longer guaranteed
    assign opcode = dec ? i_Instr[NBITS_D-1:NBITS_O] : op_q;
    bip_decoder u_dec (
        .opcode   (opcode),
        .is_mem   (d_mem),
        .is_store (d_store),
        .is_halt  (d_halt),
        .is_imm   (d_imm),
        .sel_a    (d_sel_a),
        .sel_b    (d_sel_b),
        .op       (d_op)
    );
    assign wr_acc    = (dec && d_imm) || memwb;
    assign o_WrAcc   = wr_acc;
    assign o_RdRam   = dec && d_mem;
    assign o_WrRam   = dec && d_store;
    assign o_SelA    = wr_acc ? d_sel_a : SEL_RAM;
    assign o_SelB    = wr_acc && d_sel_b;
    assign o_Op      = wr_acc && d_op;
    assign o_Operand = dec ? i_Instr[NBITS_O-1:0] : opnd_q;
    assign o_PcAddr  = pc;
    assign o_Halt    = state == HALT;
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state  <= FETCH;
            pc     <= '0;
            op_q   <= '0;
            opnd_q <= '0;
        end else begin
            case (state)
                FETCH:  state <= i_enable ? DECODE : FETCH;
                DECODE: begin
                    op_q   <= i_Instr[NBITS_D-1:NBITS_O];
                    opnd_q <= i_Instr[NBITS_O-1:0];
                    state  <= d_halt ? HALT : (d_mem ? MEMWB : FETCH);
                    pc     <= (d_halt || d_mem) ? pc : pc + 1'b1;
                end
                MEMWB: begin
                    state <= FETCH;
                    pc    <= pc + 1'b1;
                end
                HALT:   state <= HALT;
            endcase
        end
    end
`ifdef CYCLE_COUNT_EN
    logic [31:0] cnt;
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            cnt <= '0;
        else if (state != HALT && (state != FETCH || i_enable) && cnt != '1)
            cnt <= cnt + 32'd1;
    end
    assign o_CycleCount = cnt;
`endif
endmodule
